multicycle_control: RTL

Main control FSM for the multicycle MIPS core. It sequences every instruction through fetch, decode, execute, memory and writeback steps. It drives all datapath enables and mux selects, and supplies the 4-bit `aluop` consumed by the ALU decoder, which combines `aluop` with `funct` to form the 3-bit ALU control. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

---
 rtl/multicycle_control.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control FSM for the multicycle MIPS core. Sequences
//                fetch / decode / execute / memory / writeback, drives all
//                datapath enables and mux selects, and stalls on a memory
//                ready handshake.
//  Revision    : 1.0  - initial release
// ============================================================================
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state
);

  // --------------------------------------------------------------------------
  // State encoding (codes 12..15 are unused and recover to FETCH)
  // --------------------------------------------------------------------------
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTEX   = 4'd6;
  localparam logic [3:0] S_RTWB   = 4'd7;
  localparam logic [3:0] S_BEQEX  = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JEX    = 4'd11;

  // Supported opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation codes handed to the ALU decoder
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;

  // ALU B operand selects
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BRA  = 2'b11;

  // PC source selects
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // --------------------------------------------------------------------------
  // Internal signals
  // --------------------------------------------------------------------------
  logic [3:0] r_state;
  logic [3:0] w_next_state;

  logic       w_is_mem;
  logic       w_is_supported;

  logic       w_iord;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_regwrite;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [3:0] w_aluop;
  logic [1:0] w_pcsrc;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_illegal;

  // Opcode classification used by DECODE for the legality check
  assign w_is_mem       = (op == OP_LW) || (op == OP_SW);
  assign w_is_supported = w_is_mem || (op == OP_RTYPE) || (op == OP_BEQ) ||
                          (op == OP_ADDI) || (op == OP_J);

  // State register: reset is asynchronous so the FSM aborts immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic, including memory-ready stalls
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: begin
        w_next_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        if (w_is_mem) begin
          w_next_state = S_MEMADR;
        end else if (op == OP_RTYPE) begin
          w_next_state = S_RTEX;
        end else if (op == OP_BEQ) begin
          w_next_state = S_BEQEX;
        end else if (op == OP_ADDI) begin
          w_next_state = S_ADDIEX;
        end else if (op == OP_J) begin
          w_next_state = S_JEX;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_MEMADR: begin
        // op is stable since DECODE, so only lw/sw can reach here
        if (op == OP_SW) begin
          w_next_state = S_MEMWR;
        end else if (op == OP_LW) begin
          w_next_state = S_MEMRD;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_MEMRD: begin
        w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_next_state = S_FETCH;
      end
      S_MEMWR: begin
        w_next_state = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTEX: begin
        w_next_state = S_RTWB;
      end
      S_RTWB: begin
        w_next_state = S_FETCH;
      end
      S_BEQEX: begin
        w_next_state = S_FETCH;
      end
      S_ADDIEX: begin
        w_next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_next_state = S_FETCH;
      end
      S_JEX: begin
        w_next_state = S_FETCH;
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  // Output decode: Moore outputs from state, plus same-cycle mem_ready in FETCH
  always_comb begin
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = SRCB_REG;
    w_aluop    = ALU_ADD;
    w_pcsrc    = PC_ALU;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        // PC+4 is computed every cycle but only committed with the fetch data
        w_alusrcb = SRCB_FOUR;
        w_aluop   = ALU_ADD;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut
        w_alusrcb = SRCB_BRA;
        w_aluop   = ALU_ADD;
        w_illegal = ~w_is_supported;
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_IMM;
        w_aluop   = ALU_ADD;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        // Held steady across wait cycles until memory accepts the write
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_RTEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_REG;
        w_aluop   = ALU_FUNCT;
      end
      S_RTWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_REG;
        w_aluop   = ALU_SUB;
        w_pcsrc   = PC_ALUOUT;
        w_branch  = 1'b1;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_IMM;
        w_aluop   = ALU_ADD;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
      end
      S_JEX: begin
        w_pcsrc   = PC_JUMP;
        w_pcwrite = 1'b1;
      end
      default: begin
        w_aluop = ALU_ADD;
      end
    endcase
  end

  // PC and IR loads are qualified by rst_n so nothing commits while reset is low
  assign iord     = w_iord;
  assign memwrite = w_memwrite;
  assign irwrite  = w_irwrite & rst_n;
  assign regdst   = w_regdst;
  assign memtoreg = w_memtoreg;
  assign regwrite = w_regwrite;
  assign alusrca  = w_alusrca;
  assign alusrcb  = w_alusrcb;
  assign aluop    = w_aluop;
  assign pcsrc    = w_pcsrc;
  assign pcen     = (w_pcwrite | (w_branch & zero)) & rst_n;
  assign illegal  = w_illegal;
  assign state    = r_state;

endmodule
`default_nettype wire
